// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the shared fixed-point multiplier block.
//   fxp_fmt_t  - fixed-point format descriptor {width, point}
//   ovf_check  - flags a sign-extended product that does not fit the result window
//   sat_value  - most-positive / most-negative value for a given result width
// Both functions work on a 64-bit sign-extended product so they stay width-generic.
package mul_pkg;

    typedef struct packed {
        int width;
        int point;
    } fxp_fmt_t;

    // True when any bit above the result window differs from the window's sign bit.
    function automatic logic ovf_check(input logic [63:0] product, input int out_width, input int l);
        logic ovf;
        int   top;
        top = out_width + l - 1;
        ovf = 1'b0;
        for (int j = 0; j < 64; j++) begin
            ovf = ovf | ((j > top) && (product[j] != product[top]));
        end
        return ovf;
    endfunction

    // Clamp value: the low out_width bits hold 100..0 when sign is set, 011..1 otherwise.
    function automatic logic [63:0] sat_value(input logic sign, input int out_width);
        logic [63:0] pos;
        pos = (64'd1 << (out_width - 1)) - 64'd1;
        return sign ? ~pos : pos;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a rotating priority pointer.
//   clk, rst_n : clock and asynchronous active-low reset (pointer resets to 0)
//   req        : per-requester request vector
//   advance    : allow the pointer to move past the current winner this cycle
//   gnt        : one-hot grant (zero when no request), combinational
// The pointer marks the highest-priority index; it only moves when a grant is
// actually taken, so idle or stalled cycles leave the rotation untouched.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int IdxW = $clog2(N);

    logic [IdxW-1:0] ptr_r;
    logic [IdxW-1:0] gnt_idx_s;
    logic [IdxW-1:0] ptr_next_s;
    logic            found_s;
    int              slot_s;

    // Search from the pointer, wrapping modulo N; the first requester seen wins.
    always_comb begin
        gnt     = '0;
        found_s = 1'b0;
        slot_s  = 0;
        for (int off = 0; off < N; off++) begin
            slot_s      = (int'(ptr_r) + off) % N;
            gnt[slot_s] = req[slot_s] & ~found_s;
            found_s     = found_s | req[slot_s];
        end
    end

    // Encode the winner and compute the pointer position just past it.
    always_comb begin
        gnt_idx_s = '0;
        for (int i = 0; i < N; i++) begin
            gnt_idx_s = gnt_idx_s | (IdxW'(i) & {IdxW{gnt[i]}});
        end
        ptr_next_s = (gnt_idx_s == IdxW'(N - 1)) ? '0 : gnt_idx_s + IdxW'(1);
    end

    // Priority pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (advance && (|gnt)) begin
            ptr_r <= ptr_next_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: one signed fixed-point multiplier shared round-robin
// between NumReq requesters; results come back in acceptance order, tagged
// with the requester index and an overflow flag.
//   clk_i, rstn_i           : clock, asynchronous active-low reset
//   req_valid_i/a_i/b_i     : per-requester operand pair (flattened, index i at [i*W +: W])
//   req_ready_o             : per-requester accept, one-hot or zero, combinational
//   res_valid_o/ready_i     : result handshake
//   res_id_o/m_o/ovf_o      : requester index, product, overflow flag
// The multiply and formatting happen combinationally in front of a Latency-deep
// shift register; the last stage drives the result bus. A single global stall
// freezes every stage whenever a valid result is not being taken.
module mul_share_arbiter
    import mul_pkg::*;
#(
    parameter int NumReq   = 4,
    parameter int AWidth   = 16,
    parameter int APoint   = 10,
    parameter int BWidth   = 16,
    parameter int BPoint   = 10,
    parameter int OutWidth = 16,
    parameter int OutPoint = 10,
    parameter int Latency  = 2,
    parameter int Saturate = 0
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic [NumReq-1:0]           req_valid_i,
    input  logic [NumReq*AWidth-1:0]    req_a_i,
    input  logic [NumReq*BWidth-1:0]    req_b_i,
    output logic [NumReq-1:0]           req_ready_o,
    output logic                        res_valid_o,
    input  logic                        res_ready_i,
    output logic [$clog2(NumReq)-1:0]   res_id_o,
    output logic [OutWidth-1:0]         res_m_o,
    output logic                        res_ovf_o
);

    localparam int       IdW       = $clog2(NumReq);
    localparam fxp_fmt_t AFmt      = '{width: AWidth, point: APoint};
    localparam fxp_fmt_t BFmt      = '{width: BWidth, point: BPoint};
    localparam fxp_fmt_t OutFmt    = '{width: OutWidth, point: OutPoint};
    localparam int       ProdWidth = AFmt.width + BFmt.width;
    localparam int       L         = AFmt.point + BFmt.point - OutFmt.point;

    if (L < 0 || OutFmt.width + L > ProdWidth || ProdWidth > 64) begin : g_fmt_check
        $error("mul_share_arbiter: result window does not fit inside the product");
    end
    if (NumReq < 2 || Latency < 1) begin : g_param_check
        $error("mul_share_arbiter: NumReq must be >= 2 and Latency >= 1");
    end

    logic [NumReq-1:0]          gnt_s;
    logic                       stall_s;
    logic                       xfer_s;
    logic signed [AWidth-1:0]   a_sel_s;
    logic signed [BWidth-1:0]   b_sel_s;
    logic [IdW-1:0]             sel_id_s;
    logic signed [ProdWidth-1:0] p_s;
    logic [OutWidth-1:0]        m_s;
    logic                       ovf_s;

    logic                       vld_r [Latency];
    logic [IdW-1:0]             id_r  [Latency];
    logic [OutWidth-1:0]        m_r   [Latency];
    logic                       ovf_r [Latency];

    assign stall_s     = vld_r[Latency-1] & ~res_ready_i;
    // Gated by rstn_i so nothing looks accepted while reset is held.
    assign req_ready_o = gnt_s & {NumReq{~stall_s & rstn_i}};
    assign xfer_s      = |req_ready_o;

    rr_arbiter #(
        .N(NumReq)
    ) u_arb (
        .clk     (clk_i),
        .rst_n   (rstn_i),
        .req     (req_valid_i),
        .advance (~stall_s),
        .gnt     (gnt_s)
    );

    // One-hot AND-OR mux selecting the granted operand pair and its index.
    always_comb begin
        a_sel_s  = '0;
        b_sel_s  = '0;
        sel_id_s = '0;
        for (int i = 0; i < NumReq; i++) begin
            a_sel_s  = a_sel_s  | (req_a_i[i*AWidth +: AWidth] & {AWidth{gnt_s[i]}});
            b_sel_s  = b_sel_s  | (req_b_i[i*BWidth +: BWidth] & {BWidth{gnt_s[i]}});
            sel_id_s = sel_id_s | (IdW'(i) & {IdW{gnt_s[i]}});
        end
    end

    // Full-precision signed multiply, then take the output window (floor) or clamp.
    always_comb begin
        p_s   = ProdWidth'(a_sel_s) * ProdWidth'(b_sel_s);
        ovf_s = ovf_check(64'(p_s), OutWidth, L);
        if (Saturate != 0 && ovf_s) begin
            m_s = OutWidth'(sat_value(p_s[ProdWidth-1], OutWidth));
        end else begin
            m_s = p_s[OutWidth+L-1:L];
        end
    end

    // Result pipeline: shifts one stage per unstalled cycle, holds as a whole when stalled.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < Latency; k++) begin
                vld_r[k] <= 1'b0;
                id_r[k]  <= '0;
                m_r[k]   <= '0;
                ovf_r[k] <= 1'b0;
            end
        end else if (!stall_s) begin
            vld_r[0] <= xfer_s;
            id_r[0]  <= sel_id_s;
            m_r[0]   <= m_s;
            ovf_r[0] <= ovf_s;
            for (int k = 1; k < Latency; k++) begin
                vld_r[k] <= vld_r[k-1];
                id_r[k]  <= id_r[k-1];
                m_r[k]   <= m_r[k-1];
                ovf_r[k] <= ovf_r[k-1];
            end
        end
    end

    assign res_valid_o = vld_r[Latency-1];
    assign res_id_o    = id_r[Latency-1];
    assign res_m_o     = m_r[Latency-1];
    assign res_ovf_o   = ovf_r[Latency-1];

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with default parameters; a second
// instance with Saturate=1 shares the same stimulus for clamp checks.
module tb_mul_share_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        res_ready;

    logic [3:0]  req_ready,  req_ready_sat;
    logic        res_valid,  res_valid_sat;
    logic [1:0]  res_id,     res_id_sat;
    logic [15:0] res_m,      res_m_sat;
    logic        res_ovf,    res_ovf_sat;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mul_share_arbiter dut (
        .clk_i(clk), .rstn_i(rstn), .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b),
        .req_ready_o(req_ready), .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_id_o(res_id), .res_m_o(res_m), .res_ovf_o(res_ovf)
    );

    mul_share_arbiter #(.Saturate(1)) dut_sat (
        .clk_i(clk), .rstn_i(rstn), .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b),
        .req_ready_o(req_ready_sat), .res_valid_o(res_valid_sat), .res_ready_i(res_ready),
        .res_id_o(res_id_sat), .res_m_o(res_m_sat), .res_ovf_o(res_ovf_sat)
    );

    task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[i*16 +: 16] = a;
        req_b[i*16 +: 16] = b;
    endtask

    task automatic test_reset;
        rstn = 1'b0; req_valid = 4'hF; res_ready = 1'b1; req_a = '0; req_b = '0;
        @(negedge clk); #1;
        tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", res_valid); end
        tests_run++; if (res_id !== 2'd0) begin tests_failed++; $display("FAIL reset_id: got %0d expected 0", res_id); end
        tests_run++; if (res_m !== 16'h0000) begin tests_failed++; $display("FAIL reset_m: got %h expected 0000", res_m); end
        tests_run++; if (res_ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b expected 0", res_ovf); end
        tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        tests_run++; if (req_ready_sat !== 4'b0000) begin tests_failed++; $display("FAIL reset_ready_sat: got %b expected 0000", req_ready_sat); end
        req_valid = 4'h0;
        @(negedge clk); rstn = 1'b1;
    endtask

    task automatic test_single;
        @(negedge clk); req_valid = 4'b0001; set_ops(0, 16'h0600, 16'h0800); #1;
        tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
        @(negedge clk); req_valid = 4'b0000; #1;
        tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL single_early: got %b expected 0", res_valid); end
        @(negedge clk); #1;
        tests_run++; if (res_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid: got %b expected 1", res_valid); end
        tests_run++; if (res_id !== 2'd0) begin tests_failed++; $display("FAIL single_id: got %0d expected 0", res_id); end
        tests_run++; if (res_m !== 16'h0C00) begin tests_failed++; $display("FAIL single_m: got %h expected 0C00", res_m); end
        tests_run++; if (res_ovf !== 1'b0) begin tests_failed++; $display("FAIL single_ovf: got %b expected 0", res_ovf); end
        tests_run++; if (res_m_sat !== 16'h0C00 || res_valid_sat !== 1'b1) begin tests_failed++; $display("FAIL single_sat_m: got %h/%b expected 0C00/1", res_m_sat, res_valid_sat); end
        @(negedge clk); #1;
        tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL single_after: got %b expected 0", res_valid); end
    endtask

    task automatic test_overflow;
        // pointer sits at 1 after the single transfer from requester 0
        @(negedge clk); req_valid = 4'b0010; set_ops(1, 16'h4000, 16'h4000); #1;
        tests_run++; if (req_ready !== 4'b0010) begin tests_failed++; $display("FAIL ovf_ready: got %b expected 0010", req_ready); end
        @(negedge clk); req_valid = 4'b0000;
        @(negedge clk); #1;
        tests_run++; if (res_valid !== 1'b1 || res_id !== 2'd1) begin tests_failed++; $display("FAIL ovf_id: got %b/%0d expected 1/1", res_valid, res_id); end
        tests_run++; if (res_m !== 16'h0000) begin tests_failed++; $display("FAIL ovf_wrap_m: got %h expected 0000", res_m); end
        tests_run++; if (res_ovf !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %b expected 1", res_ovf); end
        tests_run++; if (res_m_sat !== 16'h7FFF) begin tests_failed++; $display("FAIL ovf_sat_m: got %h expected 7FFF", res_m_sat); end
        tests_run++; if (res_ovf_sat !== 1'b1 || res_id_sat !== 2'd1) begin tests_failed++; $display("FAIL ovf_sat_flag: got %b/%0d expected 1/1", res_ovf_sat, res_id_sat); end
        @(negedge clk);
    endtask

    task automatic test_negative;
        // pointer at 2; only requester 3 asks, so the search wraps past 2 to 3
        @(negedge clk); req_valid = 4'b1000; set_ops(3, 16'hFC00, 16'h0200); #1;
        tests_run++; if (req_ready !== 4'b1000) begin tests_failed++; $display("FAIL neg_ready: got %b expected 1000", req_ready); end
        @(negedge clk); req_valid = 4'b0000;
        @(negedge clk); #1;
        tests_run++; if (res_valid !== 1'b1 || res_id !== 2'd3) begin tests_failed++; $display("FAIL neg_id: got %b/%0d expected 1/3", res_valid, res_id); end
        tests_run++; if (res_m !== 16'hFE00 || res_ovf !== 1'b0) begin tests_failed++; $display("FAIL neg_m: got %h/%b expected FE00/0", res_m, res_ovf); end
        tests_run++; if (res_m_sat !== 16'hFE00 || res_ovf_sat !== 1'b0) begin tests_failed++; $display("FAIL neg_sat_m: got %h/%b expected FE00/0", res_m_sat, res_ovf_sat); end
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        logic [3:0]  exp_rdy;
        logic [1:0]  exp_id;
        logic [15:0] exp_m;
        for (int i = 0; i < 4; i++) set_ops(i, 16'((i + 1) * 1024), 16'h0400);
        // pointer is 0 here; requester i's product equals (i+1).0
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            exp_rdy = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
            tests_run++; if (req_ready !== exp_rdy) begin tests_failed++; $display("FAIL rr_ready c=%0d: got %b expected %b", c, req_ready, exp_rdy); end
            tests_run++; if (res_valid !== (c >= 2)) begin tests_failed++; $display("FAIL rr_valid c=%0d: got %b expected %b", c, res_valid, (c >= 2)); end
            if (c >= 2) begin
                exp_id = 2'((c - 2) % 4);
                exp_m  = 16'((((c - 2) % 4) + 1) * 1024);
                tests_run++; if (res_id !== exp_id || res_m !== exp_m) begin tests_failed++; $display("FAIL rr_result c=%0d: got %0d/%h expected %0d/%h", c, res_id, res_m, exp_id, exp_m); end
            end
        end
    endtask

    task automatic test_back_to_back_stall;
        logic [3:0] exp_rdy [0:10];
        logic       exp_vld [0:10];
        logic [1:0] exp_id  [0:10];
        logic [15:0] exp_m;
        exp_rdy = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        exp_vld = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_id  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            req_valid = (c <= 7) ? 4'hF : 4'h0;
            res_ready = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
            #1;
            tests_run++; if (req_ready !== exp_rdy[c]) begin tests_failed++; $display("FAIL stall_ready c=%0d: got %b expected %b", c, req_ready, exp_rdy[c]); end
            tests_run++; if (res_valid !== exp_vld[c]) begin tests_failed++; $display("FAIL stall_valid c=%0d: got %b expected %b", c, res_valid, exp_vld[c]); end
            if (exp_vld[c]) begin
                exp_m = 16'((int'(exp_id[c]) + 1) * 1024);
                tests_run++; if (res_id !== exp_id[c] || res_m !== exp_m) begin tests_failed++; $display("FAIL stall_result c=%0d: got %0d/%h expected %0d/%h", c, res_id, res_m, exp_id[c], exp_m); end
            end
        end
        res_ready = 1'b1;
    endtask

    task automatic test_reset_inflight;
        // pointer is 1 after the stall scenario's last grant to requester 0
        @(negedge clk); req_valid = 4'hF; #1;
        tests_run++; if (req_ready !== 4'b0010) begin tests_failed++; $display("FAIL rst_if_ready0: got %b expected 0010", req_ready); end
        @(negedge clk); #1;
        tests_run++; if (req_ready !== 4'b0100) begin tests_failed++; $display("FAIL rst_if_ready1: got %b expected 0100", req_ready); end
        @(negedge clk); #1;
        tests_run++; if (res_valid !== 1'b1 || res_id !== 2'd1) begin tests_failed++; $display("FAIL rst_if_pre: got %b/%0d expected 1/1", res_valid, res_id); end
        rstn = 1'b0; #1;
        tests_run++; if (res_valid !== 1'b0 || res_id !== 2'd0 || res_m !== 16'h0000 || res_ovf !== 1'b0) begin
            tests_failed++; $display("FAIL rst_if_outputs: got %b/%0d/%h/%b expected 0/0/0000/0", res_valid, res_id, res_m, res_ovf); end
        tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL rst_if_ready_low: got %b expected 0000", req_ready); end
        req_valid = 4'h0;
        @(negedge clk); rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_if_stale c=%0d: got %b expected 0", c, res_valid); end
        end
        @(negedge clk); req_valid = 4'hF; #1;
        tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL rst_if_ptr: got %b expected 0001", req_ready); end
        @(negedge clk); req_valid = 4'h0;
        @(negedge clk); #1;
        tests_run++; if (res_valid !== 1'b1 || res_id !== 2'd0 || res_m !== 16'h0400) begin
            tests_failed++; $display("FAIL rst_if_resume: got %b/%0d/%h expected 1/0/0400", res_valid, res_id, res_m); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_negative();
        test_round_robin();
        test_back_to_back_stall();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
